// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and instruction field positions
// shared by the ALU sequencer and its register file.
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 8;
    localparam int RS_LSB = 4;
    localparam int RT_LSB = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return op <= OP_ROR || op == OP_LDI;
    endfunction
endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: 16-entry register file, one synchronous write port and
// three combinational read ports (two operands plus debug).
module seq_regfile #(
    parameter int LEN = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           we,
    input  logic [3:0]     waddr,
    input  logic [LEN-1:0] wdata,
    input  logic [3:0]     rs_addr,
    input  logic [3:0]     rt_addr,
    input  logic [3:0]     dbg_addr,
    output logic [LEN-1:0] rs_data,
    output logic [LEN-1:0] rt_data,
    output logic [LEN-1:0] dbg_data
);
    logic [LEN-1:0] r_mem [16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) r_mem[i] <= '0;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rs_data  = r_mem[rs_addr];
    assign rt_data  = r_mem[rt_addr];
    assign dbg_data = r_mem[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: non-pipelined IDLE/READ/EXEC/WB controller that feeds an
// external combinational ALU from its register file and writes results back.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int LEN        = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [15:0]    instr,
    output logic [3:0]     alu_opcode,
    output logic [3:0]     alu_shift,
    output logic [LEN-1:0] alu_a,
    output logic [LEN-1:0] alu_b,
    output logic           alu_execute,
    input  logic [LEN-1:0] alu_result,
    input  logic [3:0]     alu_flags,
    output logic [3:0]     flags_q,
    output logic           done,
    output logic           illegal,
    input  logic [3:0]     dbg_addr,
    output logic [LEN-1:0] dbg_data
);
    localparam int CW = MUL_CYCLES > 1 ? $clog2(MUL_CYCLES) : 1;

    logic [1:0]     r_state;
    logic [15:0]    r_instr;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     w_op;
    logic [LEN-1:0] w_rs_data;
    logic [LEN-1:0] w_rt_data;
    logic           w_we;
    logic [LEN-1:0] w_wdata;

    assign w_op        = r_instr[OP_LSB +: 4];
    assign instr_ready = r_state == S_IDLE;
    assign alu_execute = r_state == S_EXEC && is_alu_op(w_op);
    assign done        = r_state == S_WB;
    assign illegal     = done && w_op > OP_LDI;
    assign w_we        = done && writes_rd(w_op);
    assign w_wdata     = w_op == OP_LDI ? {{(LEN-8){1'b0}}, r_instr[7:0]} : alu_result;

    seq_regfile #(.LEN(LEN)) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (w_we),
        .waddr    (r_instr[RD_LSB +: 4]),
        .wdata    (w_wdata),
        .rs_addr  (r_instr[RS_LSB +: 4]),
        .rt_addr  (r_instr[RT_LSB +: 4]),
        .dbg_addr (dbg_addr),
        .rs_data  (w_rs_data),
        .rt_data  (w_rt_data),
        .dbg_data (dbg_data)
    );

    // ALU inputs are only refreshed for ALU ops so they hold across LDI/illegal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_cnt      <= '0;
            alu_opcode <= '0;
            alu_shift  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            flags_q    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (instr_valid) begin
                    r_instr <= instr;
                    r_state <= S_READ;
                end
                S_READ: begin
                    if (is_alu_op(w_op)) begin
                        alu_opcode <= w_op == OP_CMP ? OP_SUB : w_op;
                        alu_shift  <= r_instr[RT_LSB +: 4];
                        alu_a      <= w_rs_data;
                        alu_b      <= w_rt_data;
                    end
                    r_cnt   <= w_op == OP_MUL ? CW'(MUL_CYCLES - 1) : '0;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_cnt == '0) r_state <= S_WB;
                    else r_cnt <= r_cnt - 1'b1;
                end
                default: begin
                    if (is_alu_op(w_op)) flags_q <= alu_flags;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors against a behavioural 16-bit ALU
// with flags {N, Z, C, V}; multiply latency set to 3 cycles.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_shift;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_execute;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  flags_q;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    logic [16:0] m_w;
    logic        m_v;
    int          n_chk = 0;
    int          n_pass = 0;
    int          dc, ec, il, rc, d;

    always #5 clk = ~clk;

    alu_sequencer #(.MUL_CYCLES(3), .LEN(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_shift   (alu_shift),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_execute (alu_execute),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .flags_q     (flags_q),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always_comb begin
        m_w = '0;
        m_v = 1'b0;
        case (alu_opcode)
            4'd0: begin
                m_w = {1'b0, alu_a} + {1'b0, alu_b};
                m_v = alu_a[15] == alu_b[15] && m_w[15] != alu_a[15];
            end
            4'd1: begin
                m_w = {1'b0, alu_a} - {1'b0, alu_b};
                m_v = alu_a[15] != alu_b[15] && m_w[15] != alu_a[15];
            end
            4'd2: m_w = {1'b0, 16'(alu_a * alu_b)};
            4'd3: m_w = {1'b0, alu_a | alu_b};
            4'd4: m_w = {1'b0, alu_a & alu_b};
            4'd5: m_w = {1'b0, alu_a ^ alu_b};
            4'd6: m_w = {1'b0, 16'(alu_a << alu_shift)};
            4'd7: m_w = {1'b0, 16'(alu_a >> alu_shift)};
            4'd8: m_w = {1'b0, 16'((alu_a >> alu_shift) | (alu_a << (5'd16 - {1'b0, alu_shift})))};
            default: m_w = '0;
        endcase
        alu_result = m_w[15:0];
        alu_flags  = {m_w[15], m_w[15:0] == 16'h0, m_w[16], m_v};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run(input logic [15:0] ins, input logic hold, input logic [15:0] hold_ins,
                       output int dcyc, output int ecnt, output int ill, output int rcnt);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        if (hold) instr = hold_ins;
        else instr_valid = 1'b0;
        dcyc = 0; ecnt = 0; ill = 0; rcnt = 0;
        for (int c = 1; c <= 12; c++) begin
            ecnt += int'(alu_execute);
            rcnt += int'(instr_ready);
            if (done) begin
                dcyc = c;
                ill  = int'(illegal);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic reg_is(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1 check(tag, dbg_data, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_flags", flags_q, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_op", alu_opcode, 0);
        reset_n = 1'b1;

        run(16'hA105, 0, 0, dc, ec, il, rc);
        check("ldi1_done_cyc", dc, 3);
        check("ldi1_exec", ec, 0);
        check("ldi1_ready", instr_ready, 1);
        reg_is("ldi1_r1", 1, 16'h0005);
        run(16'hA203, 0, 0, dc, ec, il, rc);
        check("ldi2_done_cyc", dc, 3);
        reg_is("ldi2_r2", 2, 16'h0003);

        run(16'h0312, 0, 0, dc, ec, il, rc);
        check("add_done_cyc", dc, 3);
        check("add_exec", ec, 1);
        reg_is("add_r3", 3, 16'h0008);
        check("add_flags", flags_q, 4'h0);
        check("add_alu_a_hold", alu_a, 16'h0005);
        check("add_alu_b_hold", alu_b, 16'h0003);

        run(16'h2412, 0, 0, dc, ec, il, rc);
        check("mul_done_cyc", dc, 5);
        check("mul_exec", ec, 3);
        reg_is("mul_r4", 4, 16'h000F);

        run(16'h9011, 0, 0, dc, ec, il, rc);
        check("cmp_done_cyc", dc, 3);
        check("cmp_illegal", il, 0);
        check("cmp_flags", flags_q, 4'h4);
        check("cmp_opcode", alu_opcode, 4'h1);
        reg_is("cmp_r0", 0, 16'h0000);
        reg_is("cmp_r1", 1, 16'h0005);

        run(16'h6514, 0, 0, dc, ec, il, rc);
        check("lsl_shift", alu_shift, 4'h4);
        reg_is("lsl_r5", 5, 16'h0050);
        run(16'h8611, 0, 0, dc, ec, il, rc);
        reg_is("ror_r6", 6, 16'h8002);
        check("ror_flags", flags_q, 4'h8);

        run(16'hC000, 1, 16'hA8AA, dc, ec, il, rc);
        check("ill_done_cyc", dc, 3);
        check("ill_illegal", il, 1);
        check("ill_exec", ec, 0);
        check("ill_ready_busy", rc, 0);
        check("ill_flags", flags_q, 4'h8);
        reg_is("ill_r0", 0, 16'h0000);
        reg_is("ill_r8_early", 8, 16'h0000);
        reg_is("ill_r6", 6, 16'h8002);
        run(16'hA8AA, 0, 0, dc, ec, il, rc);
        check("held_done_cyc", dc, 3);
        reg_is("held_r8", 8, 16'h00AA);

        instr = 16'h0712;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_exec", alu_execute, 1);
        reset_n = 1'b0;
        #1 check("abort_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_ready", instr_ready, 1);
        d = 0;
        for (int c = 0; c < 4; c++) begin
            d += int'(done);
            @(posedge clk); #1;
        end
        check("abort_no_done", d, 0);
        reg_is("abort_r7", 7, 16'h0000);
        reg_is("abort_r1", 1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execute controller for the 16-bit ALU datapath. Accepts 16-bit instruction words over a valid/ready handshake and holds a 16x16 register file. For each instruction it reads operands, drives the ALU's opcode/operand/shift/execute inputs, waits out the multiply latency, then writes back the result and the flags. It sits between the instruction source and the combinational ALU, and is the only block that drives the ALU.

## Interface
Parameters:
- MUL_CYCLES, 2: EXEC-state cycles for a multiply (≥1); all other ops use 1.
- LEN, 16: datapath width. Only 16 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  16  fields: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt or shift amount.
- alu_opcode  out  4  to ALU opcode.
- alu_shift  out  4  to ALU shift_bits.
- alu_a, alu_b  out  16  to ALU r2 and r3.
- alu_execute  out  1  to ALU execute.
- alu_result  in  16  from ALU r1.
- alu_flags  in  4  from ALU flags.
- flags_q  out  4  last captured flags.
- done  out  1  one-cycle pulse on write-back.
- illegal  out  1  one-cycle pulse with done when op is illegal.
- dbg_addr  in  4  debug read address.
- dbg_data  out  16  combinational regfile[dbg_addr].

## Operation
- Opcodes 0–8 go to the ALU unchanged: add, sub, mult, or, and, xor, lsl, lsr, ror.
- Op 9 (CMP): drives ALU opcode 1 (sub). Captures flags only; no register write.
- Op 10 (LDI): regfile[rd] <= {8'h00, instr[7:0]}. The ALU is not executed and flags are unchanged.
- Ops 11–15 are illegal: no register write, flags unchanged, and done and illegal pulse together.
- For ALU ops, alu_a = regfile[rs] and alu_b = regfile[rt]. For shifts (6–8), alu_shift = instr[3:0] and alu_b = regfile[rt], which the ALU ignores.
- Result width is truncated to 16 bits; this is the ALU's own width.
- States:
  - IDLE: instr_ready=1. A transfer (valid&&ready at an edge) latches instr and moves to READ.
  - READ: latches operands from the regfile into alu_a/alu_b, then moves to EXEC.
  - EXEC: alu_execute=1. Cycle counter loads MUL_CYCLES-1 for op 2, else 0. Decrements each cycle; at 0 moves to WB.
  - WB: captures alu_result/alu_flags as the op requires, performs the regfile write, done=1, then moves to IDLE.
- LDI and illegal ops still pass through READ and EXEC, with alu_execute=0 in EXEC. This keeps latency uniform.
- rd==rs or rd==rt is legal, because operands are latched in READ.
- alu_opcode, alu_shift, alu_a and alu_b hold their last values outside EXEC; only alu_execute is gated.

## Timing
- Reset values: state IDLE, all 16 registers 0, flags_q 0, alu_* outputs 0, done 0, illegal 0, instr_ready 1.
- Reset asserted mid-instruction aborts it: no write, no done. instr_ready is high in the first cycle after reset deasserts.
- Latency for a non-multiply: transfer at edge E0, READ in cycle 1, EXEC in cycle 2, WB/done in cycle 3. The result is visible on dbg_data in cycle 4, and instr_ready is high again in cycle 4.
- Latency for a multiply: done in cycle 2+MUL_CYCLES.
- Throughput is 1 instruction per 4 cycles (3+MUL_CYCLES for multiply). There is no pipelining.
- instr_ready is low in READ, EXEC and WB. instr_valid asserted then is ignored; the source must hold valid and instr until the transfer.
- Write-to-read through dbg_data: the new value appears the cycle after WB.

## Structure
- Package alu_seq_pkg holds:
  - opcode constants: OP_ADD..OP_ROR=0..8, OP_CMP=9, OP_LDI=10;
  - the state encoding: IDLE, READ, EXEC, WB;
  - field-slice constants for rd, rs and rt.
- Sub-module seq_regfile: 16x16, asynchronous reset to 0, one synchronous write port, three combinational read ports (rs, rt, dbg).
- The FSM, counter and output registers live in alu_sequencer. The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Reset, then LDI r1,0x05 and LDI r2,0x03, then ADD r3,r1,r2 with the real ALU → dbg r3=0x0008. done occurs 3 cycles after each transfer.
- MUL r4,r1,r2 with MUL_CYCLES=3 → alu_execute high exactly 3 cycles, r4=0x000F, done in cycle 5 after transfer.
- CMP r1,r1 → flags_q equals the ALU sub flags for 5−5, no register changes, done=1, illegal=0.
- LSL r5,r1 with shift 4 → r5=0x0050. ROR r6,r1 with shift 1 → r6=0x8002.
- Op 0xC → done and illegal pulse together, all registers and flags_q unchanged. instr_valid held high during EXEC is not accepted early.
- reset_n asserted in EXEC of ADD r7 → r7 stays 0, no done, and instr_ready=1 the first cycle after release.
